// File: rtl/load_align_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_align_unit_pkg
// Shared definitions for the load alignment unit:
//   - default data/func3 widths
//   - func3 load encodings (LB, LH, LW, LBU, LHU)
//   - FSM state encoding
//   - small helpers that classify a load by func3 and byte offset
// Optional feature macro used by the unit: LOAD_MISALIGN_SPLIT_EN
// -----------------------------------------------------------------------------
package load_align_unit_pkg;

   localparam int LAU_DATA_WIDTH  = 32;
   localparam int LAU_FUNC3_WIDTH = 3;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // SECOND_* states are only reachable when split reads are enabled.
   typedef enum logic [2:0] {
      ST_IDLE         = 3'd0,
      ST_WAIT         = 3'd1,
      ST_SECOND_ISSUE = 3'd2,
      ST_SECOND_WAIT  = 3'd3,
      ST_DONE         = 3'd4
   } state_t;

   function automatic logic f3_legal(input logic [2:0] f3);
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

   function automatic logic f3_is_half(input logic [2:0] f3);
      return (f3 == F3_LH) || (f3 == F3_LHU);
   endfunction

   // Any access not aligned to its natural size.
   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
      return (f3_is_half(f3) && off[0]) || ((f3 == F3_LW) && (off != 2'b00));
   endfunction

   // Misaligned accesses whose bytes run past the end of the first word.
   // A halfword at offset 1 stays inside the word and needs no second read.
   function automatic logic f3_spans_words(input logic [2:0] f3, input logic [1:0] off);
      return (f3_is_half(f3) && (off == 2'b11)) || ((f3 == F3_LW) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// -----------------------------------------------------------------------------
// load_align_unit_if
// Data BRAM read port between the load alignment unit and the memory.
//   mem_rd_en  : read strobe            (master -> slave)
//   mem_addr   : word-aligned address   (master -> slave)
//   mem_rdata  : read data, valid MEM_LATENCY cycles after the strobe
//                                       (slave -> master)
// -----------------------------------------------------------------------------
interface load_align_unit_if
   import load_align_unit_pkg::*;
#(
   parameter int DATA_WIDTH = LAU_DATA_WIDTH
);
   logic                  mem_rd_en;
   logic [DATA_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport master (
      output mem_rd_en,
      output mem_addr,
      input  mem_rdata
   );

   modport slave (
      input  mem_rd_en,
      input  mem_addr,
      output mem_rdata
   );
endinterface

// File: rtl/load_align_unit_extract.sv
// -----------------------------------------------------------------------------
// load_extract
// Combinational byte/halfword/word extraction with sign or zero extension.
// Ports:
//   window   : up to seven little-endian bytes; a single word sits in the low
//              DATA_WIDTH bits, a split access places the second word above it
//   byte_off : byte offset of the access within the first word
//   func3    : load type (LB/LH/LW/LBU/LHU); anything else yields zero
//   result   : aligned and extended value
// -----------------------------------------------------------------------------
module load_extract
   import load_align_unit_pkg::*;
#(
   parameter int DATA_WIDTH = LAU_DATA_WIDTH,
   parameter int WIN_WIDTH  = 2*DATA_WIDTH - 8
)(
   input  logic [WIN_WIDTH-1:0]  window,
   input  logic [1:0]            byte_off,
   input  logic [2:0]            func3,
   output logic [DATA_WIDTH-1:0] result
);

   // One candidate per byte offset; the top lane ends exactly at the top of
   // the window, which is why the window is seven bytes rather than eight.
   logic [DATA_WIDTH-1:0] lane_win [4];
   logic [DATA_WIDTH-1:0] sel;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_win[gi] = window[8*gi +: DATA_WIDTH];
      end
   endgenerate

   assign sel = lane_win[byte_off];

   always_comb begin
      result = '0;
      case (func3)
         F3_LB:   result = {{(DATA_WIDTH-8){sel[7]}}, sel[7:0]};
         F3_LH:   result = {{(DATA_WIDTH-16){sel[15]}}, sel[15:0]};
         F3_LW:   result = sel;
         F3_LBU:  result = {{(DATA_WIDTH-8){1'b0}}, sel[7:0]};
         F3_LHU:  result = {{(DATA_WIDTH-16){1'b0}}, sel[15:0]};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/load_align_unit.sv
// -----------------------------------------------------------------------------
// load_align_unit
// Load-side data formatter between the data BRAM read port and write-back.
// Captures a load request, issues a word-aligned BRAM read, waits out the read
// latency, then extracts/extends the addressed byte, halfword or word and
// presents it with a one-cycle valid pulse. busy stalls the core meanwhile.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   load_req        : request, only accepted in IDLE
//   func3           : load type
//   alu_result_addr : byte address
//   mem             : BRAM read port (master side)
//   load_data       : registered result (zero on error)
//   load_valid      : one-cycle pulse with the result
//   busy            : stall request while the access is in flight
//   load_err        : one-cycle pulse with load_valid on misalign/illegal func3
//
// Optional feature: define LOAD_MISALIGN_SPLIT_EN to service loads that
// straddle two words with a second read instead of flagging an error.
// -----------------------------------------------------------------------------
module load_align_unit
   import load_align_unit_pkg::*;
#(
   parameter int DATA_WIDTH  = LAU_DATA_WIDTH,
   parameter int FUNC3_WIDTH = LAU_FUNC3_WIDTH,
   parameter int MEM_LATENCY = 1
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load_req,
   input  logic [FUNC3_WIDTH-1:0] func3,
   input  logic [DATA_WIDTH-1:0]  alu_result_addr,
   load_align_unit_if.master      mem,
   output logic [DATA_WIDTH-1:0]  load_data,
   output logic                   load_valid,
   output logic                   busy,
   output logic                   load_err
);

   // The counter expires in the cycle read data is valid.
   localparam logic [1:0] CNT_INIT  = 2'(MEM_LATENCY - 1);
   localparam int         WIN_WIDTH = 2*DATA_WIDTH - 8;

   state_t                  state_reg, state_next;
   logic [1:0]              cnt_reg, cnt_next;
   logic [FUNC3_WIDTH-1:0]  func3_reg;
   logic [1:0]              off_reg;
   logic [DATA_WIDTH-1:0]   load_data_reg;
   logic                    load_err_reg;

   logic                    accept;
   logic                    finish;
   logic                    err_c;
   logic [WIN_WIDTH-1:0]    window;
   logic [DATA_WIDTH-1:0]   extracted;

`ifdef LOAD_MISALIGN_SPLIT_EN
   logic [DATA_WIDTH-3:0]   word_addr_reg;
   logic [DATA_WIDTH-1:0]   word0_reg;
   logic                    split_c;

   assign err_c   = !f3_legal(func3_reg);
   assign split_c = f3_legal(func3_reg) && f3_spans_words(func3_reg, off_reg);
   // Second half of a split access: earlier word low, current word high.
   assign window  = (state_reg == ST_SECOND_WAIT) ?
                    {mem.mem_rdata[DATA_WIDTH-9:0], word0_reg} :
                    {{(DATA_WIDTH-8){1'b0}}, mem.mem_rdata};
`else
   assign err_c  = !f3_legal(func3_reg) || f3_misaligned(func3_reg, off_reg);
   assign window = {{(DATA_WIDTH-8){1'b0}}, mem.mem_rdata};
`endif

   load_extract #(
      .DATA_WIDTH (DATA_WIDTH),
      .WIN_WIDTH  (WIN_WIDTH)
   ) u_extract (
      .window   (window),
      .byte_off (off_reg),
      .func3    (func3_reg),
      .result   (extracted)
   );

   // Next-state, read strobe and capture controls
   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      accept        = 1'b0;
      finish        = 1'b0;
      mem.mem_rd_en = 1'b0;
      mem.mem_addr  = '0;

      case (state_reg)
         ST_IDLE: begin
            // Gated by rst so nothing is strobed while reset is held.
            if (load_req && !rst) begin
               accept        = 1'b1;
               mem.mem_rd_en = 1'b1;
               mem.mem_addr  = {alu_result_addr[DATA_WIDTH-1:2], 2'b00};
               cnt_next      = CNT_INIT;
               state_next    = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (cnt_reg == 2'd0) begin
`ifdef LOAD_MISALIGN_SPLIT_EN
               if (split_c) begin
                  state_next = ST_SECOND_ISSUE;
               end else begin
                  finish     = 1'b1;
                  state_next = ST_DONE;
               end
`else
               finish     = 1'b1;
               state_next = ST_DONE;
`endif
            end else begin
               cnt_next = cnt_reg - 2'd1;
            end
         end

`ifdef LOAD_MISALIGN_SPLIT_EN
         ST_SECOND_ISSUE: begin
            // Word address increment wraps at the top of the address space.
            mem.mem_rd_en = 1'b1;
            mem.mem_addr  = {word_addr_reg + 1'b1, 2'b00};
            cnt_next      = CNT_INIT;
            state_next    = ST_SECOND_WAIT;
         end

         ST_SECOND_WAIT: begin
            if (cnt_reg == 2'd0) begin
               finish     = 1'b1;
               state_next = ST_DONE;
            end else begin
               cnt_next = cnt_reg - 2'd1;
            end
         end
`endif

         ST_DONE: begin
            // Requests here are ignored; the core re-presents them in IDLE.
            state_next = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         func3_reg     <= '0;
         off_reg       <= '0;
         load_data_reg <= '0;
         load_err_reg  <= 1'b0;
`ifdef LOAD_MISALIGN_SPLIT_EN
         word_addr_reg <= '0;
         word0_reg     <= '0;
`endif
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (accept) begin
            func3_reg <= func3;
            off_reg   <= alu_result_addr[1:0];
`ifdef LOAD_MISALIGN_SPLIT_EN
            word_addr_reg <= alu_result_addr[DATA_WIDTH-1:2];
`endif
         end
`ifdef LOAD_MISALIGN_SPLIT_EN
         if ((state_reg == ST_WAIT) && (cnt_reg == 2'd0)) begin
            word0_reg <= mem.mem_rdata;
         end
`endif
         if (finish) begin
            load_data_reg <= err_c ? '0 : extracted;
         end
         // Set only on the transition into DONE, so it pulses with load_valid.
         load_err_reg <= finish && err_c;
      end
   end

   assign load_data  = load_data_reg;
   assign load_err   = load_err_reg;
   assign load_valid = (state_reg == ST_DONE);
   assign busy       = (state_reg == ST_WAIT) ||
                       (state_reg == ST_SECOND_ISSUE) ||
                       (state_reg == ST_SECOND_WAIT);

endmodule

// File: tb/tb_load_align_unit.sv
// -----------------------------------------------------------------------------
// tb_load_align_unit
// Two instances: dut1 with MEM_LATENCY=1, dut3 with MEM_LATENCY=3, each with
// its own BRAM model. Expected results are queued when a load is issued and
// popped by a per-instance monitor whenever load_valid is seen. Timing of
// mem_rd_en/mem_addr/busy/load_valid is checked by the stimulus task.
// Expectations follow LOAD_MISALIGN_SPLIT_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_load_align_unit;
   import load_align_unit_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        req1, req3;
   logic [2:0]  f3_1, f3_3;
   logic [31:0] addr1, addr3;
   logic [31:0] data1, data3;
   logic        valid1, valid3, busy1, busy3, err1, err3;

   load_align_unit_if #(.DATA_WIDTH(32)) bus1 ();
   load_align_unit_if #(.DATA_WIDTH(32)) bus3 ();

   load_align_unit #(.DATA_WIDTH(32), .FUNC3_WIDTH(3), .MEM_LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .load_req(req1), .func3(f3_1), .alu_result_addr(addr1),
      .mem(bus1), .load_data(data1), .load_valid(valid1), .busy(busy1), .load_err(err1));

   load_align_unit #(.DATA_WIDTH(32), .FUNC3_WIDTH(3), .MEM_LATENCY(3)) dut3 (
      .clk(clk), .rst(rst), .load_req(req3), .func3(f3_3), .alu_result_addr(addr3),
      .mem(bus3), .load_data(data3), .load_valid(valid3), .busy(busy3), .load_err(err3));

   // BRAM models: data appears exactly MEM_LATENCY cycles after a strobe,
   // and a poison value otherwise so mistimed sampling is visible.
   logic [31:0] mem [64];
   logic [31:0] p3 [3];

   always @(posedge clk) begin
      bus1.mem_rdata <= bus1.mem_rd_en ? mem[bus1.mem_addr[7:2]] : 32'hDEAD_BEEF;
      p3[0] <= bus3.mem_rd_en ? mem[bus3.mem_addr[7:2]] : 32'hDEAD_BEEF;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign bus3.mem_rdata = p3[2];

   int checks;
   int errors;
   logic [32:0] q1[$];
   logic [32:0] q3[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic g_rd(input int d);
      return (d == 0) ? bus1.mem_rd_en : bus3.mem_rd_en;
   endfunction
   function automatic logic [31:0] g_addr(input int d);
      return (d == 0) ? bus1.mem_addr : bus3.mem_addr;
   endfunction
   function automatic logic g_busy(input int d);
      return (d == 0) ? busy1 : busy3;
   endfunction
   function automatic logic g_valid(input int d);
      return (d == 0) ? valid1 : valid3;
   endfunction

   task automatic drive(input int d, input logic r, input logic [2:0] f, input logic [31:0] a);
      if (d == 0) begin
         req1 = r; f3_1 = f; addr1 = a;
      end else begin
         req3 = r; f3_3 = f; addr3 = a;
      end
   endtask

   // Issue one load in cycle N and check timing up to the valid cycle N+cycles.
   // second_at: offset of the second read strobe (0 = none).
   task automatic do_load(input int d, input string nm, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] exp_data,
                          input logic exp_err, input int cycles,
                          input int second_at, input logic [31:0] addr2);
      @(negedge clk);
      drive(d, 1'b1, f, a);
      if (d == 0) q1.push_back({exp_err, exp_data});
      else        q3.push_back({exp_err, exp_data});
      #1;
      chk({nm, " rd_en N"}, 32'(g_rd(d)), 32'd1);
      chk({nm, " addr N"}, g_addr(d), {a[31:2], 2'b00});
      chk({nm, " busy N"}, 32'(g_busy(d)), 32'd0);
      @(negedge clk);
      drive(d, 1'b0, f, a);
      for (int k = 1; k < cycles; k++) begin
         if (k > 1) @(negedge clk);
         #1;
         chk($sformatf("%s busy N+%0d", nm, k), 32'(g_busy(d)), 32'd1);
         chk($sformatf("%s valid N+%0d", nm, k), 32'(g_valid(d)), 32'd0);
         if (k == second_at) begin
            chk($sformatf("%s rd_en2 N+%0d", nm, k), 32'(g_rd(d)), 32'd1);
            chk($sformatf("%s addr2 N+%0d", nm, k), g_addr(d), addr2);
         end else begin
            chk($sformatf("%s rd_en N+%0d", nm, k), 32'(g_rd(d)), 32'd0);
            chk($sformatf("%s addr N+%0d", nm, k), g_addr(d), 32'd0);
         end
      end
      @(negedge clk);
      #1;
      chk($sformatf("%s valid N+%0d", nm, cycles), 32'(g_valid(d)), 32'd1);
      chk($sformatf("%s busy N+%0d", nm, cycles), 32'(g_busy(d)), 32'd0);
   endtask

   // Scoreboard monitors
   always @(negedge clk) begin
      logic [32:0] exp;
      if (valid1) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL dut1 result: got unexpected valid data=%h err=%b required none", data1, err1);
         end else begin
            exp = q1.pop_front();
            $display("dut1 load data=%h err=%b", data1, err1);
            if ({err1, data1} !== exp) begin
               errors++;
               $display("FAIL dut1 result: got err=%b data=%h required err=%b data=%h",
                        err1, data1, exp[32], exp[31:0]);
            end
         end
      end else if (err1) begin
         checks++; errors++;
         $display("FAIL dut1 err_pulse: got load_err=1 without load_valid required 0");
      end
   end

   always @(negedge clk) begin
      logic [32:0] exp;
      if (valid3) begin
         checks++;
         if (q3.size() == 0) begin
            errors++;
            $display("FAIL dut3 result: got unexpected valid data=%h err=%b required none", data3, err3);
         end else begin
            exp = q3.pop_front();
            $display("dut3 load data=%h err=%b", data3, err3);
            if ({err3, data3} !== exp) begin
               errors++;
               $display("FAIL dut3 result: got err=%b data=%h required err=%b data=%h",
                        err3, data3, exp[32], exp[31:0]);
            end
         end
      end else if (err3) begin
         checks++; errors++;
         $display("FAIL dut3 err_pulse: got load_err=1 without load_valid required 0");
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[32] = 32'h8A7F_1234;   // 0x80
      mem[33] = 32'h0000_00CC;   // 0x84
      rst = 1'b1;
      drive(0, 1'b0, F3_LB, 32'h0);
      drive(1, 1'b0, F3_LB, 32'h0);
      repeat (3) @(negedge clk);
      #1;
      chk("rst data1", data1, 32'h0);
      chk("rst valid1", 32'(valid1), 32'h0);
      chk("rst busy1", 32'(busy1), 32'h0);
      chk("rst err1", 32'(err1), 32'h0);
      chk("rst rd_en1", 32'(bus1.mem_rd_en), 32'h0);
      chk("rst addr1", bus1.mem_addr, 32'h0);
      chk("rst data3", data3, 32'h0);
      chk("rst valid3", 32'(valid3), 32'h0);
      chk("rst busy3", 32'(busy3), 32'h0);
      rst = 1'b0;

      do_load(0, "lb_83",  F3_LB,  32'h83, 32'hFFFF_FF8A, 1'b0, 2, 0, 32'h0);
      do_load(0, "lbu_83", F3_LBU, 32'h83, 32'h0000_008A, 1'b0, 2, 0, 32'h0);
      do_load(0, "lhu_82", F3_LHU, 32'h82, 32'h0000_8A7F, 1'b0, 2, 0, 32'h0);
      do_load(0, "lh_80",  F3_LH,  32'h80, 32'h0000_1234, 1'b0, 2, 0, 32'h0);
      do_load(0, "lh_82",  F3_LH,  32'h82, 32'hFFFF_8A7F, 1'b0, 2, 0, 32'h0);
      do_load(0, "lb_81",  F3_LB,  32'h81, 32'h0000_0012, 1'b0, 2, 0, 32'h0);
      do_load(1, "lw_80_l3", F3_LW, 32'h80, 32'h8A7F_1234, 1'b0, 4, 0, 32'h0);
`ifdef LOAD_MISALIGN_SPLIT_EN
      do_load(0, "lw_81",  F3_LW,  32'h81, 32'hCC8A_7F12, 1'b0, 4, 2, 32'h84);
      do_load(0, "lh_81",  F3_LH,  32'h81, 32'h0000_7F12, 1'b0, 2, 0, 32'h0);
      do_load(0, "lhu_83", F3_LHU, 32'h83, 32'h0000_CC8A, 1'b0, 4, 2, 32'h84);
`else
      do_load(0, "lw_81",  F3_LW,  32'h81, 32'h0, 1'b1, 2, 0, 32'h0);
      do_load(0, "lh_81",  F3_LH,  32'h81, 32'h0, 1'b1, 2, 0, 32'h0);
      do_load(0, "lhu_83", F3_LHU, 32'h83, 32'h0, 1'b1, 2, 0, 32'h0);
`endif
      do_load(0, "f3_011", 3'b011, 32'h80, 32'h0, 1'b1, 2, 0, 32'h0);
      do_load(0, "f3_110", 3'b110, 32'h80, 32'h0, 1'b1, 2, 0, 32'h0);
      do_load(0, "lw_80",  F3_LW,  32'h80, 32'h8A7F_1234, 1'b0, 2, 0, 32'h0);

      // Reset while dut3 is waiting on the BRAM: no result may follow.
      @(negedge clk);
      drive(1, 1'b1, F3_LW, 32'h80);
      @(negedge clk);
      drive(1, 1'b0, F3_LW, 32'h80);
      #1;
      chk("rstwait busy_pre", 32'(busy3), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstwait data3", data3, 32'h0);
      chk("rstwait busy3", 32'(busy3), 32'h0);
      chk("rstwait valid3", 32'(valid3), 32'h0);
      chk("rstwait err3", 32'(err3), 32'h0);
      chk("rstwait rd_en3", 32'(bus3.mem_rd_en), 32'h0);
      chk("rstwait addr3", bus3.mem_addr, 32'h0);
      chk("rstwait data1", data1, 32'h0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("rstwait novalid %0d", k), 32'(valid3), 32'h0);
      end

      // load_req held high: three loads, one every three cycles.
      @(negedge clk);
      drive(0, 1'b1, F3_LBU, 32'h83);
      for (int i = 0; i < 3; i++) q1.push_back({1'b0, 32'h0000_008A});
      for (int t = 0; t < 9; t++) begin
         if (t > 0) @(negedge clk);
         #1;
         chk($sformatf("b2b rd_en t%0d", t), 32'(bus1.mem_rd_en), 32'((t % 3) == 0));
         chk($sformatf("b2b valid t%0d", t), 32'(valid1), 32'((t % 3) == 2));
         chk($sformatf("b2b busy t%0d", t), 32'(busy1), 32'((t % 3) == 1));
      end
      drive(0, 1'b0, F3_LBU, 32'h83);

      repeat (6) @(negedge clk);
      #1;
      chk("sb1 drained", 32'(q1.size()), 32'h0);
      chk("sb3 drained", 32'(q3.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
